// File: rtl/dsp_window_accum.sv
// dsp_window_accum
// Sums signed products over windows of WIN_LEN valid samples and counts the
// pattern hits in each window. Each window result is held in a valid/ready
// output register. If a window closes while the previous result has not been
// accepted, the new result is dropped and ovf_o is set (sticky).
//
// Optional feature macro: ACC_SAT_EN
//   defined   -> every add saturates, and sat_o reports a clamp in the window
//   undefined -> the sum wraps modulo 2^ACC_W, and sat_o stays 0
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i               begin a window run (sampled only in IDLE)
//   cont_i                re-arm after each window close
//   valid_i/prod_i/match_i  input sample, its signed product and its hit flag
//   out_valid_o/out_ready_i output handshake
//   acc_o, hits_o, sat_o  window result
//   busy_o                high while in RUN
//   ovf_o                 sticky flag: a result was dropped
module dsp_window_accum #(
  parameter int P_W     = 43,
  parameter int ACC_W   = 48,
  parameter int WIN_LEN = 16,
  localparam int CNT_W  = $clog2(WIN_LEN+1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    cont_i,
  input  logic                    valid_i,
  input  logic signed [P_W-1:0]   prod_i,
  input  logic                    match_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic signed [ACC_W-1:0] acc_o,
  output logic [CNT_W-1:0]        hits_o,
  output logic                    busy_o,
  output logic                    ovf_o,
  output logic                    sat_o
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, acco_q, acco_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, hit_q, hit_d, hitso_q, hitso_d;
  logic                    ov_q, ov_d, ovf_q, ovf_d;
  logic                    satw_q, satw_d, sato_q, sato_d;

  logic signed [ACC_W-1:0] p_ext, add_res;
  logic                    add_sat;
  logic [CNT_W-1:0]        hit_inc;
  logic                    accept, close;

  assign p_ext = ACC_W'(prod_i);

`ifdef ACC_SAT_EN
  // One guard bit: the add overflowed when the top two bits disagree; the
  // guard bit then holds the true sign and selects the clamp direction.
  logic signed [ACC_W:0] wide;
  assign wide    = {acc_q[ACC_W-1], acc_q} + {p_ext[ACC_W-1], p_ext};
  assign add_sat = wide[ACC_W] ^ wide[ACC_W-1];
  assign add_res = !add_sat ? wide[ACC_W-1:0] :
                   wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                               : {1'b0, {(ACC_W-1){1'b1}}};
`else
  assign add_res = acc_q + p_ext;
  assign add_sat = 1'b0;
`endif

  assign hit_inc = hit_q + CNT_W'(match_i);
  assign accept  = ov_q && out_ready_i;
  assign close   = (state_q == RUN) && valid_i && (cnt_q == CNT_W'(WIN_LEN-1));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    hit_d   = hit_q;
    satw_d  = satw_q;
    ov_d    = ov_q;
    acco_d  = acco_q;
    hitso_d = hitso_q;
    sato_d  = sato_q;
    ovf_d   = ovf_q;

    if (accept) ov_d = 1'b0;

    case (state_q)
      IDLE: if (start_i) begin
        state_d = RUN;
        acc_d   = '0;
        cnt_d   = '0;
        hit_d   = '0;
        satw_d  = 1'b0;
        ovf_d   = 1'b0;
      end
      RUN: if (valid_i) begin
        acc_d  = add_res;
        cnt_d  = cnt_q + 1'b1;
        hit_d  = hit_inc;
        satw_d = satw_q | add_sat;
        if (close) begin
          // A slot is free if empty, or if it is being emptied this cycle.
          if (!ov_q || accept) begin
            ov_d    = 1'b1;
            acco_d  = add_res;
            hitso_d = hit_inc;
            sato_d  = satw_q | add_sat;
          end else begin
            ovf_d = 1'b1;
          end
          acc_d  = '0;
          cnt_d  = '0;
          hit_d  = '0;
          satw_d = 1'b0;
          if (!cont_i) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      hit_q   <= '0;
      satw_q  <= 1'b0;
      ov_q    <= 1'b0;
      acco_q  <= '0;
      hitso_q <= '0;
      sato_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      satw_q  <= satw_d;
      ov_q    <= ov_d;
      acco_q  <= acco_d;
      hitso_q <= hitso_d;
      sato_q  <= sato_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid_o = ov_q;
  assign acc_o       = acco_q;
  assign hits_o      = hitso_q;
  assign busy_o      = (state_q == RUN);
  assign ovf_o       = ovf_q;
  assign sat_o       = sato_q;

endmodule
